// File: rtl/leaf_link_pkg.sv
// rtl/leaf_link_pkg.sv - shared state type and constants for the leaf egress link
package leaf_link_pkg;

  // Link presentation state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } link_state_t;

  // Width of the optional statistics counters
  localparam int CNT_BITS = 32;

  // Index of the packet valid flag (packet MSB)
  function automatic int valid_bit(input int packet_bits);
    return packet_bits - 1;
  endfunction

endpackage

// File: rtl/leaf_link_fifo.sv
// rtl/leaf_link_fifo.sv - register-array packet FIFO with push/pop/clear and count
module leaf_link_fifo
  import leaf_link_pkg::*;
#(
  parameter int WIDTH      = 97,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign empty   = (count == '0);
  assign full    = count[DEPTH_BITS];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Packet storage; contents are only meaningful below count, so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo depth; clear dominates push and pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_egress_link.sv
// rtl/leaf_egress_link.sv - leaf-to-switch egress adapter; LEAF_EGRESS_STATS_EN adds pkts_sent/pkts_rejected counters
module leaf_egress_link
  import leaf_link_pkg::*;
#(
  parameter int PACKET_BITS     = 97,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PACKET_BITS-1:0]     stream_in,
  output logic                       resend,
  input  logic                       flush,
  output logic [PACKET_BITS-1:0]     link_out,
  input  logic                       link_ack,
  output logic [FIFO_DEPTH_BITS:0]   occupancy
`ifdef LEAF_EGRESS_STATS_EN
  ,
  output logic [CNT_BITS-1:0]        pkts_sent,
  output logic [CNT_BITS-1:0]        pkts_rejected
`endif
);

  localparam int                     VB        = valid_bit(PACKET_BITS);
  localparam logic [FIFO_DEPTH_BITS:0] COUNT_ONE = {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};

  link_state_t              state_q;
  link_state_t              state_d;
  logic [PACKET_BITS-1:0]   head;
  logic [FIFO_DEPTH_BITS:0] count;
  logic                     fifo_full;
  logic                     in_valid;
  logic                     in_flush;
  logic                     pop;
  logic                     push;
  logic                     reject;
  logic                     last_entry;
  logic                     resend_q;

  // A flush request blocks writes in the cycle it is raised, not only once FLUSH is reached,
  // otherwise a packet accepted alongside the clear would vanish without a resend.
  assign in_valid   = stream_in[VB];
  assign in_flush   = flush || (state_q == FLUSH);
  assign pop        = (state_q == SEND) && link_ack;
  assign push       = in_valid && !in_flush && (!fifo_full || pop);
  assign reject     = in_valid && !push;
  assign last_entry = (count == COUNT_ONE);

  assign resend     = resend_q;
  assign occupancy  = count;

  leaf_link_fifo #(
    .WIDTH      (PACKET_BITS),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_data  (stream_in),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (fifo_full)
  );

  // Next-state and link output; the head is only presented while in SEND
  always_comb begin
    state_d  = state_q;
    link_out = '0;
    if (state_q == SEND) begin
      link_out = head;
    end
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_d = SEND;
          end
        end
        SEND: begin
          if (pop && last_entry && !push) begin
            state_d = IDLE;
          end
        end
        FLUSH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register and one-cycle resend pulse per rejected packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      resend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resend_q <= reject;
    end
  end

`ifdef LEAF_EGRESS_STATS_EN
  // Saturating statistics; an ack coinciding with flush still counts as sent
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkts_sent     <= '0;
      pkts_rejected <= '0;
    end else begin
      if (pop && (pkts_sent != '1)) begin
        pkts_sent <= pkts_sent + 1'b1;
      end
      if (reject && (pkts_rejected != '1)) begin
        pkts_rejected <= pkts_rejected + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_egress_link.sv
// tb/tb_leaf_egress_link.sv - scoreboard bench for leaf_egress_link
module tb_leaf_egress_link;

  localparam int PB    = 97;
  localparam int DB    = 3;
  localparam int DEPTH = 8;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic            flush     = 1'b0;
  logic            link_ack  = 1'b0;
  logic [PB-1:0]   stream_in = '0;
  logic            resend;
  logic [PB-1:0]   link_out;
  logic [DB:0]     occupancy;
`ifdef LEAF_EGRESS_STATS_EN
  logic [31:0]     pkts_sent;
  logic [31:0]     pkts_rejected;
`endif

  leaf_egress_link #(
    .PACKET_BITS     (PB),
    .FIFO_DEPTH_BITS (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stream_in     (stream_in),
    .resend        (resend),
    .flush         (flush),
    .link_out      (link_out),
    .link_ack      (link_ack),
    .occupancy     (occupancy)
`ifdef LEAF_EGRESS_STATS_EN
    ,
    .pkts_sent     (pkts_sent),
    .pkts_rejected (pkts_rejected)
`endif
  );

  int            n_checks    = 0;
  int            n_pass      = 0;
  int            resend_seen = 0;
  bit            mon_en      = 1'b0;
  logic [PB-1:0] sb_q [$];
  logic          m_flushing  = 1'b0;
  logic          m_resend    = 1'b0;
  int unsigned   m_sent      = 0;
  int unsigned   m_rej       = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PB-1:0] mk(input int n);
    return {1'b1, 64'hC0DE_0000_0000_0000, 32'(n)};
  endfunction

  task automatic cyc(input logic [PB-1:0] d, input logic ack, input logic fl);
    stream_in = d;
    link_ack  = ack;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle: compare DUT outputs to the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin : mon
    logic v, p, a, fi;
    if (mon_en) begin
      if (!m_flushing && sb_q.size() > 0) chk("link_out", link_out, sb_q[0]);
      else                                chk("link_out_idle", link_out, '0);
      chk("occupancy", occupancy, sb_q.size());
      chk("resend", resend, m_resend);
`ifdef LEAF_EGRESS_STATS_EN
      chk("pkts_sent", pkts_sent, m_sent);
      chk("pkts_rejected", pkts_rejected, m_rej);
`endif
      if (resend) resend_seen++;
      v  = stream_in[PB-1];
      fi = flush || m_flushing;
      p  = !m_flushing && (sb_q.size() > 0) && link_ack;
      a  = v && !fi && ((sb_q.size() < DEPTH) || p);
      if (p) begin
        chk("pop_data", link_out, sb_q[0]);
        void'(sb_q.pop_front());
        m_sent++;
      end
      m_resend = v && !a;
      if (m_resend) m_rej++;
      if (flush) sb_q.delete();
      else if (a) sb_q.push_back(stream_in);
      m_flushing = flush;
    end
  end

  initial begin
    int r0;
    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_link_out", link_out, '0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_resend", resend, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    // Single packet, ack in cycle 3
    cyc({1'b1, 96'hAB}, 1'b0, 1'b0);
    chk("single_c1", link_out, {1'b1, 96'hAB});
    chk("single_occ1", occupancy, 1);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("single_c3", link_out, {1'b1, 96'hAB});
    cyc('0, 1'b1, 1'b0);
    chk("single_c4", link_out, '0);
    chk("single_occ0", occupancy, 0);
    cyc('0, 1'b0, 1'b0);

    // Fill to full with one overflow
    r0 = resend_seen;
    for (int i = 0; i < 9; i++) cyc(mk(10 + i), 1'b0, 1'b0);
    chk("fill_occ8", occupancy, DEPTH);
    chk("fill_resend_now", resend, 1);
    cyc('0, 1'b0, 1'b0);
    chk("fill_resend_once", resend_seen - r0, 1);
    chk("fill_head", link_out, mk(10));

    // Full with simultaneous ack and write
    r0 = resend_seen;
    cyc(mk(18), 1'b1, 1'b0);
    chk("full_ack_occ8", occupancy, DEPTH);
    chk("full_ack_no_resend", resend, 0);
    for (int i = 0; i < 10; i++) cyc('0, 1'b1, 1'b0);
    chk("full_ack_resends", resend_seen - r0, 0);
    chk("drain_occ0", occupancy, 0);

    // Streaming with ack held high
    for (int i = 0; i < 20; i++) begin
      cyc(mk(100 + i), 1'b1, 1'b0);
      chk("stream_occ_le1", occupancy <= 1, 1'b1);
    end
    cyc('0, 1'b1, 1'b0);
    cyc('0, 1'b1, 1'b0);
    chk("stream_empty", occupancy, 0);

    // Flush with five queued, valid input offered, ack in first flush cycle
    for (int i = 0; i < 5; i++) cyc(mk(200 + i), 1'b0, 1'b0);
    chk("flush_pre_occ", occupancy, 5);
    r0 = resend_seen;
    cyc(mk(210), 1'b1, 1'b1);
    chk("flush_occ0", occupancy, 0);
    chk("flush_link0", link_out, '0);
    cyc(mk(211), 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("flush_resends", resend_seen - r0, 2);
    cyc(mk(220), 1'b0, 1'b0);
    chk("post_flush_send", link_out, mk(220));
    cyc('0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0);

    // Asynchronous reset mid-transfer while resend is high
    for (int i = 0; i < 9; i++) cyc(mk(300 + i), 1'b0, 1'b0);
    stream_in = '0;
    #2;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_link_out", link_out, '0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_resend", resend, 0);
`ifdef LEAF_EGRESS_STATS_EN
    chk("arst_sent", pkts_sent, 0);
    chk("arst_rejected", pkts_rejected, 0);
`endif
    sb_q.delete();
    m_flushing = 1'b0;
    m_resend   = 1'b0;
    m_sent     = 0;
    m_rej      = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    cyc(mk(400), 1'b0, 1'b0);
    chk("post_rst_send", link_out, mk(400));
    cyc('0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/leaf_egress_link.md
# leaf_egress_link

Egress link adapter between a leaf's `Stream_Flow_Control` `stream_out` and the BFT switch leaf port. Absorbs outgoing packets into a small FIFO, presents them to the switch under a hold-until-ack handshake, and drives `resend` back to the flow-control block's converge controller when a packet could not be absorbed. A `flush` input discards the queue.

## Interface
- `PACKET_BITS`, 97, packet width; bit `PACKET_BITS-1` is the valid flag, the rest is opaque.
- `FIFO_DEPTH_BITS`, 3, FIFO holds `2**FIFO_DEPTH_BITS` packets.
- `clk` input 1: single clock, the BFT clock domain.
- `reset` input 1: asynchronous, active-low.
- `stream_in` input `PACKET_BITS`: packet from `Stream_Flow_Control.stream_out`; valid when MSB = 1.
- `resend` output 1: to `Stream_Flow_Control.resend`; the packet offered last cycle was rejected and must be re-presented.
- `flush` input 1: synchronous discard of all queued packets.
- `link_out` output `PACKET_BITS`: packet to switch; all-zero when nothing is presented.
- `link_ack` input 1: switch accepted the packet on `link_out` this cycle.
- `occupancy` output `FIFO_DEPTH_BITS+1`: current FIFO count.

## Operation
FSM states:
- **IDLE**: FIFO empty, `link_out` = 0.
- **SEND**: FIFO non-empty; head packet driven on `link_out` and held stable until `link_ack`.
- **FLUSH**: entered while `flush` = 1; FIFO emptied; all writes rejected.

Transitions:
- IDLE→SEND on a write.
- SEND→IDLE when an ack pops the last entry with no simultaneous write.
- Any state→FLUSH on `flush`.
- FLUSH→IDLE on the first cycle `flush` = 0.

Write acceptance:
- A valid `stream_in` is written iff not in FLUSH and (count < depth, or count == depth with a pop in the same cycle).
- Otherwise the packet is rejected, and `resend` is 1 in the next cycle.
- Invalid `stream_in` is never written and never causes `resend`.

Pop and ack rules:
- Pop occurs iff state is SEND and `link_ack` = 1.
- `link_ack` is ignored in IDLE and in FLUSH.

Pointers and count:
- Read and write pointers are `FIFO_DEPTH_BITS` wide and wrap modulo depth.
- Count is `FIFO_DEPTH_BITS+1` bits. It is unchanged on a simultaneous push and pop, and never overflows or underflows.

Flush with a pending ack: if `flush` and `link_ack` coincide, flush wins. The acked packet counts as sent (it is counted by the optional counters), and the FIFO is still cleared.

## Timing
- Reset values: `link_out` = 0, `resend` = 0, `occupancy` = 0, state IDLE, pointers 0. Reset may assert mid-transfer; the in-flight packet is lost without any ack being required.
- Write-to-`link_out` latency is 1 cycle: a packet written at edge N appears at N+1 when the FIFO was empty.
- Back-to-back: an ack at edge N pops, and the next head is on `link_out` from N+1 with no bubble.
- `resend` is registered: it is high at cycle N+1 for a rejection at cycle N, and high for exactly one cycle per rejection.
- `occupancy` is registered and reflects the state after the edge.

## Configuration
- `LEAF_EGRESS_STATS_EN` defined adds two 32-bit saturating output counters, both cleared by reset:
  - `pkts_sent`: incremented per pop.
  - `pkts_rejected`: incremented per rejection.
- Without the macro, these ports and their logic are absent and the behaviour is otherwise identical.

## Structure
- Package `leaf_link_pkg` holds:
  - the state enum (IDLE, SEND, FLUSH),
  - the `VALID_BIT` index function of `PACKET_BITS`,
  - the counter width constant 32.
- One sub-module, `leaf_link_fifo`: synchronous register-array FIFO with push/pop/clear ports and count output. The FSM and `resend` logic live in the top.

## Test plan
- **Single packet**: `stream_in` = 0x1_0000…00AB for 1 cycle, `link_ack` at cycle 3 → `link_out` = packet in cycles 1–3, 0 from cycle 4, `occupancy` goes 1→0, `resend` never high.
- **Fill to full**: 9 consecutive valid packets with depth 8 and no ack → first 8 are stored, the 9th is rejected, `resend` = 1 for exactly one cycle, `occupancy` = 8.
- **Full with simultaneous ack**: FIFO full, valid input plus `link_ack` in the same cycle → write accepted, `occupancy` stays 8, no `resend`.
- **Streaming**: 20 packets in, `link_ack` held high → in-order output, one packet per cycle, pointer wraparound exercised, `occupancy` ≤ 1.
- **Flush**: 5 queued, `flush` 2 cycles while a valid input is offered → `occupancy` = 0, `link_out` = 0, offered packets cause `resend`, IDLE afterward.
- **Asynchronous reset**: reset pulse mid-SEND between clock edges → all outputs 0 immediately; with `LEAF_EGRESS_STATS_EN`, counters read 0.
